mem_access: RTL and testbench

Memory-access stage of the cqu_mips five-stage pipeline. It sits between the execute stage and write-back. It consumes the execute stage's result, destination, and HI/LO outputs, and performs byte/half/word loads and stores over a request/acknowledge data-memory port. It also flags misaligned accesses and memory timeouts. Loads are sign- or zero-extended here. The block back-pressures execute while a memory transaction is outstanding.

---
 rtl/mem_access.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_mem_access.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access - memory-access stage of the cqu_mips five-stage pipeline.
//
// Takes the execute stage's result, destination and HI/LO outputs and either
// passes them straight to write-back (non-memory ops), reports an address
// exception (misaligned loads/stores), or runs one transaction on the
// request/acknowledge data-memory port. Loads are extended here; stores are
// lane-replicated with byte strobes. A wait counter aborts a request that is
// not acknowledged within TIMEOUT cycles.
//
// Ports:
//   clk, rstn                     clock, asynchronous active-low reset
//   ex_valid / ex_ready           execute handshake (ready only in IDLE)
//   ex_alu_result, ex_store_data  address or ALU result, store data (rt)
//   ex_mem_op                     0 none, 1 LB .. 8 SW, 9-15 none
//   ex_waddr, ex_reg_write        destination register and write enable
//   ex_hi, ex_lo, ex_whilo        HI/LO values and write enable
//   dm_req/we/addr/wstrb/wdata    data-memory request, held until ack
//   dm_ack, dm_rdata              completion and read data
//   wb_*                          write-back fields, wb_valid pulses 1 cycle
//   exc_adel/exc_ades/exc_bus     load misalign, store misalign, timeout
//   badvaddr                      faulting address for any exc_* flag
//
// Handshake: an op transfers on a rising clk edge where ex_valid && ex_ready;
// the memory port transfers on the edge where dm_req && dm_ack, and dm_req is
// held with all dm_* stable until then (or until the timeout abort).
module mem_access #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [3:0]  ex_mem_op,
    input  logic [4:0]  ex_waddr,
    input  logic        ex_reg_write,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    input  logic        ex_whilo,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_wstrb,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_waddr,
    output logic        wb_reg_write,
    output logic [31:0] wb_wdata,
    output logic [31:0] wb_hi,
    output logic [31:0] wb_lo,
    output logic        wb_whilo,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        exc_bus,
    output logic [31:0] badvaddr
);

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    // Counter value in the last cycle dm_req may be held.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    function automatic logic is_load(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_LW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
        case (op)
            OP_LH, OP_LHU, OP_SH: return a[0];
            OP_LW, OP_SW:         return a != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [3:0] op, input logic [1:0] a);
        case (op)
            OP_SB:   return 4'b0001 << a;
            OP_SH:   return a[1] ? 4'b1100 : 4'b0011;
            OP_SW:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] d);
        case (op)
            OP_SB:   return {4{d[7:0]}};
            OP_SH:   return {2{d[15:0]}};
            OP_SW:   return d;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] load_data(input logic [3:0] op, input logic [1:0] a,
                                              input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        case (op)
            OP_LB:   return {{24{b[7]}}, b};
            OP_LBU:  return {24'd0, b};
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'd0, h};
            default: return rd;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    // Write-back fields of the op waiting on memory.
    logic [4:0]  p_waddr_q, p_waddr_d;
    logic        p_reg_write_q, p_reg_write_d;
    logic [31:0] p_hi_q, p_hi_d, p_lo_q, p_lo_d;
    logic        p_whilo_q, p_whilo_d;
    logic        dm_req_q, dm_req_d, dm_we_q, dm_we_d;
    logic [3:0]  dm_wstrb_q, dm_wstrb_d;
    logic [31:0] dm_wdata_q, dm_wdata_d;
    logic        wb_valid_q, wb_valid_d, wb_reg_write_q, wb_reg_write_d;
    logic [4:0]  wb_waddr_q, wb_waddr_d;
    logic [31:0] wb_wdata_q, wb_wdata_d, wb_hi_q, wb_hi_d, wb_lo_q, wb_lo_d;
    logic        wb_whilo_q, wb_whilo_d;
    logic        exc_adel_q, exc_adel_d, exc_ades_q, exc_ades_d, exc_bus_q, exc_bus_d;
    logic [31:0] badvaddr_q, badvaddr_d;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        op_d           = op_q;
        addr_d         = addr_q;
        p_waddr_d      = p_waddr_q;
        p_reg_write_d  = p_reg_write_q;
        p_hi_d         = p_hi_q;
        p_lo_d         = p_lo_q;
        p_whilo_d      = p_whilo_q;
        dm_req_d       = dm_req_q;
        dm_we_d        = dm_we_q;
        dm_wstrb_d     = dm_wstrb_q;
        dm_wdata_d     = dm_wdata_q;
        wb_valid_d     = 1'b0;
        wb_waddr_d     = wb_waddr_q;
        wb_reg_write_d = wb_reg_write_q;
        wb_wdata_d     = wb_wdata_q;
        wb_hi_d        = wb_hi_q;
        wb_lo_d        = wb_lo_q;
        wb_whilo_d     = wb_whilo_q;
        exc_adel_d     = exc_adel_q;
        exc_ades_d     = exc_ades_q;
        exc_bus_d      = exc_bus_q;
        badvaddr_d     = badvaddr_q;

        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (!is_load(ex_mem_op) && !is_store(ex_mem_op)) begin
                        wb_valid_d     = 1'b1;
                        wb_waddr_d     = ex_waddr;
                        wb_reg_write_d = ex_reg_write;
                        wb_wdata_d     = ex_alu_result;
                        wb_hi_d        = ex_hi;
                        wb_lo_d        = ex_lo;
                        wb_whilo_d     = ex_whilo;
                        exc_adel_d     = 1'b0;
                        exc_ades_d     = 1'b0;
                        exc_bus_d      = 1'b0;
                    end else if (misaligned(ex_mem_op, ex_alu_result[1:0])) begin
                        // Faulting op: suppress every architectural write.
                        wb_valid_d     = 1'b1;
                        wb_waddr_d     = ex_waddr;
                        wb_reg_write_d = 1'b0;
                        wb_wdata_d     = ex_alu_result;
                        wb_hi_d        = ex_hi;
                        wb_lo_d        = ex_lo;
                        wb_whilo_d     = 1'b0;
                        exc_adel_d     = is_load(ex_mem_op);
                        exc_ades_d     = is_store(ex_mem_op);
                        exc_bus_d      = 1'b0;
                        badvaddr_d     = ex_alu_result;
                    end else begin
                        state_d       = REQ;
                        cnt_d         = 8'd0;
                        op_d          = ex_mem_op;
                        addr_d        = ex_alu_result;
                        p_waddr_d     = ex_waddr;
                        p_reg_write_d = ex_reg_write;
                        p_hi_d        = ex_hi;
                        p_lo_d        = ex_lo;
                        p_whilo_d     = ex_whilo;
                        dm_req_d      = 1'b1;
                        dm_we_d       = is_store(ex_mem_op);
                        dm_wstrb_d    = store_strb(ex_mem_op, ex_alu_result[1:0]);
                        dm_wdata_d    = store_data(ex_mem_op, ex_store_data);
                    end
                end
            end
            REQ: begin
                // Ack wins over a timeout falling in the same cycle.
                if (dm_ack || cnt_q == CNT_LAST) begin
                    state_d        = IDLE;
                    dm_req_d       = 1'b0;
                    wb_valid_d     = 1'b1;
                    wb_waddr_d     = p_waddr_q;
                    wb_hi_d        = p_hi_q;
                    wb_lo_d        = p_lo_q;
                    exc_adel_d     = 1'b0;
                    exc_ades_d     = 1'b0;
                    exc_bus_d      = !dm_ack;
                    wb_reg_write_d = dm_ack && p_reg_write_q;
                    wb_whilo_d     = dm_ack && p_whilo_q;
                    wb_wdata_d     = (dm_ack && is_load(op_q))
                                     ? load_data(op_q, addr_q[1:0], dm_rdata) : addr_q;
                    if (!dm_ack) begin
                        badvaddr_d = addr_q;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= IDLE;
            cnt_q          <= 8'd0;
            op_q           <= 4'd0;
            addr_q         <= 32'd0;
            p_waddr_q      <= 5'd0;
            p_reg_write_q  <= 1'b0;
            p_hi_q         <= 32'd0;
            p_lo_q         <= 32'd0;
            p_whilo_q      <= 1'b0;
            dm_req_q       <= 1'b0;
            dm_we_q        <= 1'b0;
            dm_wstrb_q     <= 4'd0;
            dm_wdata_q     <= 32'd0;
            wb_valid_q     <= 1'b0;
            wb_waddr_q     <= 5'd0;
            wb_reg_write_q <= 1'b0;
            wb_wdata_q     <= 32'd0;
            wb_hi_q        <= 32'd0;
            wb_lo_q        <= 32'd0;
            wb_whilo_q     <= 1'b0;
            exc_adel_q     <= 1'b0;
            exc_ades_q     <= 1'b0;
            exc_bus_q      <= 1'b0;
            badvaddr_q     <= 32'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            op_q           <= op_d;
            addr_q         <= addr_d;
            p_waddr_q      <= p_waddr_d;
            p_reg_write_q  <= p_reg_write_d;
            p_hi_q         <= p_hi_d;
            p_lo_q         <= p_lo_d;
            p_whilo_q      <= p_whilo_d;
            dm_req_q       <= dm_req_d;
            dm_we_q        <= dm_we_d;
            dm_wstrb_q     <= dm_wstrb_d;
            dm_wdata_q     <= dm_wdata_d;
            wb_valid_q     <= wb_valid_d;
            wb_waddr_q     <= wb_waddr_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_wdata_q     <= wb_wdata_d;
            wb_hi_q        <= wb_hi_d;
            wb_lo_q        <= wb_lo_d;
            wb_whilo_q     <= wb_whilo_d;
            exc_adel_q     <= exc_adel_d;
            exc_ades_q     <= exc_ades_d;
            exc_bus_q      <= exc_bus_d;
            badvaddr_q     <= badvaddr_d;
        end
    end

    assign ex_ready     = (state_q == IDLE);
    assign dm_req       = dm_req_q;
    assign dm_we        = dm_we_q;
    assign dm_addr      = {addr_q[31:2], 2'b00};
    assign dm_wstrb     = dm_wstrb_q;
    assign dm_wdata     = dm_wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_waddr     = wb_waddr_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_wdata     = wb_wdata_q;
    assign wb_hi        = wb_hi_q;
    assign wb_lo        = wb_lo_q;
    assign wb_whilo     = wb_whilo_q;
    assign exc_adel     = exc_adel_q;
    assign exc_ades     = exc_ades_q;
    assign exc_bus      = exc_bus_q;
    assign badvaddr     = badvaddr_q;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

    logic        clk;
    logic        rstn;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [3:0]  ex_mem_op;
    logic [4:0]  ex_waddr;
    logic        ex_reg_write;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic        ex_whilo;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        wb_valid;
    logic [4:0]  wb_waddr;
    logic        wb_reg_write;
    logic [31:0] wb_wdata;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        wb_whilo;
    logic        exc_adel;
    logic        exc_ades;
    logic        exc_bus;
    logic [31:0] badvaddr;

    int checks = 0;
    int errors = 0;

    mem_access #(.TIMEOUT(4)) dut (
        .clk(clk), .rstn(rstn),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_mem_op(ex_mem_op), .ex_waddr(ex_waddr), .ex_reg_write(ex_reg_write),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wstrb(dm_wstrb),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .wb_valid(wb_valid), .wb_waddr(wb_waddr), .wb_reg_write(wb_reg_write),
        .wb_wdata(wb_wdata), .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo),
        .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_bus(exc_bus),
        .badvaddr(badvaddr)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] sdata, input logic [4:0] waddr,
                            input logic reg_write);
        ex_valid      = 1'b1;
        ex_mem_op     = op;
        ex_alu_result = addr;
        ex_store_data = sdata;
        ex_waddr      = waddr;
        ex_reg_write  = reg_write;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        ex_valid = 1'b0; ex_alu_result = '0; ex_store_data = '0; ex_mem_op = '0;
        ex_waddr = '0; ex_reg_write = 1'b0; ex_hi = '0; ex_lo = '0; ex_whilo = 1'b0;
        dm_ack = 1'b0; dm_rdata = '0;
        #1;
        checks++;
        if (ex_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ex_ready: got %b expected 1", ex_ready);
        end
        checks++;
        if ({dm_req, dm_we, dm_wstrb, dm_addr, dm_wdata} !== '0) begin
            errors++; $display("FAIL reset_dm: got req=%b we=%b strb=%h addr=%h wdata=%h expected all 0",
                               dm_req, dm_we, dm_wstrb, dm_addr, dm_wdata);
        end
        checks++;
        if ({wb_valid, wb_waddr, wb_reg_write, wb_wdata, wb_hi, wb_lo, wb_whilo,
             exc_adel, exc_ades, exc_bus, badvaddr} !== '0) begin
            errors++; $display("FAIL reset_wb: got valid=%b wdata=%h exc=%b%b%b badvaddr=%h expected all 0",
                               wb_valid, wb_wdata, exc_adel, exc_ades, exc_bus, badvaddr);
        end
        repeat (2) step();
        rstn = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        int ready_low = 0;
        drive_op(4'd0, 32'h11, 32'h0, 5'd3, 1'b1);
        ex_hi = 32'hAAAA_0001; ex_lo = 32'h5555_0001; ex_whilo = 1'b1;
        if (ex_ready !== 1'b1) ready_low++;
        step();
        checks++;
        if (wb_valid !== 1'b1 || wb_wdata !== 32'h11 || wb_waddr !== 5'd3 || wb_reg_write !== 1'b1) begin
            errors++; $display("FAIL b2b_first: got valid=%b wdata=%h waddr=%0d rw=%b expected 1 00000011 3 1",
                               wb_valid, wb_wdata, wb_waddr, wb_reg_write);
        end
        checks++;
        if (wb_hi !== 32'hAAAA_0001 || wb_lo !== 32'h5555_0001 || wb_whilo !== 1'b1) begin
            errors++; $display("FAIL b2b_hilo: got hi=%h lo=%h whilo=%b expected aaaa0001 55550001 1",
                               wb_hi, wb_lo, wb_whilo);
        end
        if (ex_ready !== 1'b1) ready_low++;
        drive_op(4'd12, 32'h22, 32'h0, 5'd4, 1'b1);
        ex_whilo = 1'b0;
        step();
        checks++;
        if (wb_valid !== 1'b1 || wb_wdata !== 32'h22 || wb_waddr !== 5'd4 || wb_whilo !== 1'b0) begin
            errors++; $display("FAIL b2b_second: got valid=%b wdata=%h waddr=%0d whilo=%b expected 1 00000022 4 0",
                               wb_valid, wb_wdata, wb_waddr, wb_whilo);
        end
        if (ex_ready !== 1'b1) ready_low++;
        ex_valid = 1'b0;
        step();
        checks++;
        if (wb_valid !== 1'b0 || ready_low != 0) begin
            errors++; $display("FAIL b2b_end: got valid=%b ready_low_cycles=%0d expected 0 0",
                               wb_valid, ready_low);
        end
    endtask

    // One aligned load with `waits` idle request cycles before the ack.
    task automatic do_load(input string name, input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] rdata, input int waits,
                           input logic [31:0] exp_data);
        int req_cycles = 0;
        int early_wb   = 0;
        int addr_bad   = 0;
        drive_op(op, addr, 32'h0, 5'd5, 1'b1);
        step();
        ex_valid = 1'b0;
        checks++;
        if (dm_req !== 1'b1 || dm_we !== 1'b0 || dm_wstrb !== 4'd0 || ex_ready !== 1'b0) begin
            errors++; $display("FAIL %s_issue: got req=%b we=%b strb=%b ready=%b expected 1 0 0000 0",
                               name, dm_req, dm_we, dm_wstrb, ex_ready);
        end
        for (int i = 0; i <= waits; i++) begin
            if (dm_req === 1'b1) req_cycles++;
            if (wb_valid !== 1'b0) early_wb++;
            if (dm_addr !== {addr[31:2], 2'b00}) addr_bad++;
            if (i == waits) begin
                dm_ack = 1'b1; dm_rdata = rdata;
            end
            step();
            dm_ack = 1'b0; dm_rdata = 32'h0;
        end
        checks++;
        if (req_cycles != waits + 1 || early_wb != 0 || addr_bad != 0) begin
            errors++; $display("FAIL %s_req: got req_cycles=%0d early_wb=%0d bad_addr_cycles=%0d expected %0d 0 0",
                               name, req_cycles, early_wb, addr_bad, waits + 1);
        end
        checks++;
        if (wb_valid !== 1'b1 || dm_req !== 1'b0 || wb_wdata !== exp_data ||
            wb_reg_write !== 1'b1 || wb_waddr !== 5'd5 ||
            {exc_adel, exc_ades, exc_bus} !== 3'b000) begin
            errors++; $display("FAIL %s_result: got valid=%b req=%b wdata=%h rw=%b waddr=%0d exc=%b%b%b expected 1 0 %h 1 5 000",
                               name, wb_valid, dm_req, wb_wdata, wb_reg_write, wb_waddr,
                               exc_adel, exc_ades, exc_bus, exp_data);
        end
        step();
        checks++;
        if (wb_valid !== 1'b0 || ex_ready !== 1'b1 || wb_wdata !== exp_data) begin
            errors++; $display("FAIL %s_after: got valid=%b ready=%b wdata=%h expected 0 1 %h",
                               name, wb_valid, ex_ready, wb_wdata, exp_data);
        end
    endtask

    task automatic test_loads();
        do_load("lb",  4'd1, 32'h0000_1003, 32'h80FF_1234, 2, 32'hFFFF_FF80);
        do_load("lbu", 4'd2, 32'h0000_1003, 32'h80FF_1234, 2, 32'h0000_0080);
        do_load("lb1", 4'd1, 32'h0000_1001, 32'h80FF_1234, 0, 32'h0000_0012);
        do_load("lh",  4'd3, 32'h0000_1002, 32'h80FF_1234, 1, 32'hFFFF_80FF);
        do_load("lhu", 4'd4, 32'h0000_1000, 32'h80FF_9234, 0, 32'h0000_9234);
        do_load("lw",  4'd5, 32'h0000_1004, 32'h80FF_1234, 0, 32'h80FF_1234);
    endtask

    task automatic do_store(input string name, input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] sdata, input logic [3:0] exp_strb,
                            input logic [31:0] exp_wdata);
        drive_op(op, addr, sdata, 5'd0, 1'b0);
        step();
        ex_valid = 1'b0;
        checks++;
        if (dm_req !== 1'b1 || dm_we !== 1'b1 || dm_wstrb !== exp_strb ||
            dm_wdata !== exp_wdata || dm_addr !== {addr[31:2], 2'b00}) begin
            errors++; $display("FAIL %s_issue: got req=%b we=%b strb=%b wdata=%h addr=%h expected 1 1 %b %h %h",
                               name, dm_req, dm_we, dm_wstrb, dm_wdata, dm_addr,
                               exp_strb, exp_wdata, {addr[31:2], 2'b00});
        end
        dm_ack = 1'b1;
        step();
        dm_ack = 1'b0;
        checks++;
        if (wb_valid !== 1'b1 || dm_req !== 1'b0 || wb_reg_write !== 1'b0 ||
            {exc_adel, exc_ades, exc_bus} !== 3'b000) begin
            errors++; $display("FAIL %s_done: got valid=%b req=%b rw=%b exc=%b%b%b expected 1 0 0 000",
                               name, wb_valid, dm_req, wb_reg_write, exc_adel, exc_ades, exc_bus);
        end
        step();
    endtask

    task automatic test_stores();
        do_store("sh", 4'd7, 32'h0000_2002, 32'hDEAD_BEEF, 4'b1100, 32'hBEEF_BEEF);
        do_store("sb", 4'd6, 32'h0000_2001, 32'h1234_56A5, 4'b0010, 32'hA5A5_A5A5);
        do_store("sw", 4'd8, 32'h0000_2004, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    endtask

    task automatic do_misaligned(input string name, input logic [3:0] op,
                                 input logic [31:0] addr, input logic exp_adel,
                                 input logic exp_ades);
        drive_op(op, addr, 32'h0, 5'd7, 1'b1);
        ex_whilo = 1'b1;
        step();
        ex_valid = 1'b0; ex_whilo = 1'b0;
        checks++;
        if (dm_req !== 1'b0 || wb_valid !== 1'b1 || exc_adel !== exp_adel ||
            exc_ades !== exp_ades || exc_bus !== 1'b0 || badvaddr !== addr ||
            wb_reg_write !== 1'b0 || wb_whilo !== 1'b0 || ex_ready !== 1'b1) begin
            errors++; $display("FAIL %s: got req=%b valid=%b adel=%b ades=%b bus=%b bad=%h rw=%b whilo=%b ready=%b expected 0 1 %b %b 0 %h 0 0 1",
                               name, dm_req, wb_valid, exc_adel, exc_ades, exc_bus, badvaddr,
                               wb_reg_write, wb_whilo, ex_ready, exp_adel, exp_ades, addr);
        end
        step();
    endtask

    task automatic test_misaligned();
        do_misaligned("mis_lw", 4'd5, 32'h0000_3002, 1'b1, 1'b0);
        do_misaligned("mis_sw", 4'd8, 32'h0000_3001, 1'b0, 1'b1);
        do_misaligned("mis_lh", 4'd3, 32'h0000_3001, 1'b1, 1'b0);
        do_misaligned("mis_sh", 4'd7, 32'h0000_3003, 1'b0, 1'b1);
        // A clean op afterwards clears the flags.
        drive_op(4'd0, 32'h99, 32'h0, 5'd1, 1'b1);
        step();
        ex_valid = 1'b0;
        checks++;
        if (wb_valid !== 1'b1 || {exc_adel, exc_ades, exc_bus} !== 3'b000 || wb_wdata !== 32'h99) begin
            errors++; $display("FAIL exc_clear: got valid=%b exc=%b%b%b wdata=%h expected 1 000 00000099",
                               wb_valid, exc_adel, exc_ades, exc_bus, wb_wdata);
        end
        step();
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        int n = 0;
        drive_op(4'd5, 32'h0000_4000, 32'h0, 5'd9, 1'b1);
        step();
        ex_valid = 1'b0;
        while (wb_valid !== 1'b1 && n < 12) begin
            if (dm_req === 1'b1) req_cycles++;
            step();
            n++;
        end
        checks++;
        if (req_cycles != 4 || wb_valid !== 1'b1 || exc_bus !== 1'b1 || dm_req !== 1'b0 ||
            badvaddr !== 32'h0000_4000 || wb_reg_write !== 1'b0 || exc_adel !== 1'b0) begin
            errors++; $display("FAIL timeout: got req_cycles=%0d valid=%b bus=%b req=%b bad=%h rw=%b adel=%b expected 4 1 1 0 00004000 0 0",
                               req_cycles, wb_valid, exc_bus, dm_req, badvaddr, wb_reg_write, exc_adel);
        end
        step();
        checks++;
        if (ex_ready !== 1'b1 || wb_valid !== 1'b0) begin
            errors++; $display("FAIL timeout_idle: got ready=%b valid=%b expected 1 0", ex_ready, wb_valid);
        end
        // Ack in the last allowed cycle is a normal completion.
        do_load("ack_at_limit", 4'd5, 32'h0000_4008, 32'h1234_5678, 3, 32'h1234_5678);
    endtask

    task automatic test_reset_mid_req();
        int wb_seen = 0;
        drive_op(4'd5, 32'h0000_5000, 32'h0, 5'd2, 1'b1);
        step();
        ex_valid = 1'b0;
        checks++;
        if (dm_req !== 1'b1) begin
            errors++; $display("FAIL rst_pre: got req=%b expected 1", dm_req);
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (dm_req !== 1'b0 || ex_ready !== 1'b1 || wb_valid !== 1'b0) begin
            errors++; $display("FAIL rst_async: got req=%b ready=%b valid=%b expected 0 1 0",
                               dm_req, ex_ready, wb_valid);
        end
        dm_ack = 1'b1;
        step();
        dm_ack = 1'b0;
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (wb_valid !== 1'b0 || dm_req !== 1'b0) wb_seen++;
            step();
        end
        checks++;
        if (wb_seen != 0 || ex_ready !== 1'b1) begin
            errors++; $display("FAIL rst_after: got stray_cycles=%0d ready=%b expected 0 1",
                               wb_seen, ex_ready);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_loads();
        test_stores();
        test_misaligned();
        test_timeout();
        test_reset_mid_req();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
